// File: rtl/button_conditioner.sv
// Debounced, auto-repeating push-button conditioner: per-channel 2-flop
// synchronizer, debounce FSM and hold/repeat timer with registered strobes.
module button_conditioner #(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned HOLD_CYCLES     = 13500000,
  parameter int unsigned REPEAT_CYCLES   = 2700000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] held,
  output logic [NUM_BTN-1:0] released
);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_REL
  } state_t;

  // Hold and repeat intervals are measured from the cycle after the strobe,
  // so their terminal counts are the full interval rather than interval-1.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES);

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] p;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign p = ~sync2;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             press_nx;
    logic             rel_nx;
    logic             held_nx;
    logic             press_q;
    logic             held_q;
    logic             rel_q;

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      press_nx = 1'b0;
      rel_nx   = 1'b0;
      unique case (state)
        IDLE: begin
          if (p[g]) begin
            state_nx = DB_PRESS;
            cnt_nx   = '0;
          end
        end
        DB_PRESS: begin
          if (!p[g]) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == DB_LAST) begin
            state_nx = HELD;
            cnt_nx   = '0;
            press_nx = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!p[g]) begin
            state_nx = DB_REL;
            cnt_nx   = '0;
          end else if (cnt == HOLD_LAST) begin
            state_nx = REPEAT;
            cnt_nx   = '0;
            press_nx = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!p[g]) begin
            state_nx = DB_REL;
            cnt_nx   = '0;
          end else if (cnt == REP_LAST) begin
            cnt_nx   = '0;
            press_nx = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        DB_REL: begin
          if (p[g]) begin
            state_nx = HELD;
            cnt_nx   = '0;
          end else if (cnt == DB_LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            rel_nx   = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end

    assign held_nx = (state_nx == HELD) || (state_nx == REPEAT) || (state_nx == DB_REL);

    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= IDLE;
        cnt     <= '0;
        press_q <= 1'b0;
        held_q  <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state   <= state_nx;
        cnt     <= cnt_nx;
        press_q <= press_nx;
        held_q  <= held_nx;
        rel_q   <= rel_nx;
      end
    end

    assign press[g]    = press_q;
    assign held[g]     = held_q;
    assign released[g] = rel_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold/repeat
// intervals; expected strobe edges are counted from the first sampling edge.
module tb_button_conditioner;

  localparam int unsigned NUM_BTN = 2;
  localparam int unsigned DB      = 4;
  localparam int unsigned HOLD    = 10;
  localparam int unsigned REP     = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned MAXC    = (HOLD > DB) ? ((HOLD > REP) ? HOLD : REP) : ((DB > REP) ? DB : REP);

  if (MAXC > (1 << CNT_W) - 1) begin : g_cnt_w_check
    initial $fatal(1, "CNT_W=%0d too narrow for interval %0d", CNT_W, MAXC);
  end

  logic               clk;
  logic               rst;
  logic [NUM_BTN-1:0] btn_n;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] held;
  logic [NUM_BTN-1:0] released;

  int checks;
  int failures;

  button_conditioner #(
    .NUM_BTN        (NUM_BTN),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP),
    .CNT_W          (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_n   (btn_n),
    .press   (press),
    .held    (held),
    .released(released)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] ep, eh, er;
    rst   = 1'b1;
    btn_n = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({press, held, released} !== 6'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got p=%b h=%b r=%b want 0", i, press, held, released);
      end
    end
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      ep = (e == 6) ? 2'b11 : 2'b00;
      eh = (e >= 6) ? 2'b11 : 2'b00;
      er = 2'b00;
      checks++;
      if ({press, held, released} !== {ep, eh, er}) begin
        failures++;
        $display("FAIL reset_press E%0d got p=%b h=%b r=%b want p=%b h=%b r=%b", e, press, held, released, ep, eh, er);
      end
    end
    btn_n = 2'b11;
    for (int e = 0; e < 8; e++) begin
      tick();
      ep = 2'b00;
      eh = (e < 6) ? 2'b11 : 2'b00;
      er = (e == 6) ? 2'b11 : 2'b00;
      checks++;
      if ({press, held, released} !== {ep, eh, er}) begin
        failures++;
        $display("FAIL reset_release E%0d got p=%b h=%b r=%b want p=%b h=%b r=%b", e, press, held, released, ep, eh, er);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [1:0] ep, eh, er;
    btn_n = 2'b10;
    for (int e = 0; e < 29; e++) begin
      if (e == 20) btn_n = 2'b11;
      tick();
      ep = (e == 6 || e == 17 || e == 21) ? 2'b01 : 2'b00;
      eh = (e >= 6 && e < 26) ? 2'b01 : 2'b00;
      er = (e == 26) ? 2'b01 : 2'b00;
      checks++;
      if ({press, held, released} !== {ep, eh, er}) begin
        failures++;
        $display("FAIL clean_press E%0d got p=%b h=%b r=%b want p=%b h=%b r=%b", e, press, held, released, ep, eh, er);
      end
    end
  endtask

  task automatic test_bounce_reject();
    for (int e = 0; e < 16; e++) begin
      if (e < 3 || e == 4 || e == 5) btn_n = 2'b10;
      else btn_n = 2'b11;
      tick();
      checks++;
      if ({press, held, released} !== 6'b0) begin
        failures++;
        $display("FAIL bounce_reject E%0d got p=%b h=%b r=%b want 0", e, press, held, released);
      end
    end
  endtask

  task automatic test_release_bounce();
    logic [1:0] ep, eh, er;
    for (int e = 0; e < 26; e++) begin
      btn_n = (e == 8 || e == 9) ? 2'b11 : 2'b10;
      tick();
      ep = (e == 6 || e == 23) ? 2'b01 : 2'b00;
      eh = (e >= 6) ? 2'b01 : 2'b00;
      er = 2'b00;
      checks++;
      if ({press, held, released} !== {ep, eh, er}) begin
        failures++;
        $display("FAIL release_bounce E%0d got p=%b h=%b r=%b want p=%b h=%b r=%b", e, press, held, released, ep, eh, er);
      end
    end
    btn_n = 2'b11;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (held !== 2'b00) begin
      failures++;
      $display("FAIL release_bounce_idle got h=%b want 00", held);
    end
  endtask

  task automatic test_auto_repeat();
    logic [1:0] ep, eh, er;
    for (int e = 0; e < 48; e++) begin
      btn_n = (e < 39) ? 2'b01 : 2'b11;
      tick();
      ep = (e == 6 || e == 17 || e == 21 || e == 25 || e == 29 || e == 33 || e == 37) ? 2'b10 : 2'b00;
      eh = (e >= 6 && e < 45) ? 2'b10 : 2'b00;
      er = (e == 45) ? 2'b10 : 2'b00;
      checks++;
      if ({press, held, released} !== {ep, eh, er}) begin
        failures++;
        $display("FAIL auto_repeat E%0d got p=%b h=%b r=%b want p=%b h=%b r=%b", e, press, held, released, ep, eh, er);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [1:0] ep, eh, er;
    btn_n = 2'b10;
    for (int e = 0; e < 19; e++) begin
      tick();
      ep = (e == 6 || e == 17) ? 2'b01 : 2'b00;
      eh = (e >= 6) ? 2'b01 : 2'b00;
      checks++;
      if ({press, held, released} !== {ep, eh, 2'b00}) begin
        failures++;
        $display("FAIL mid_hold_pre E%0d got p=%b h=%b r=%b want p=%b h=%b r=00", e, press, held, released, ep, eh);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({press, held, released} !== 6'b0) begin
      failures++;
      $display("FAIL mid_hold_reset got p=%b h=%b r=%b want 0", press, held, released);
    end
    rst = 1'b0;
    for (int e = 0; e < 9; e++) begin
      tick();
      ep = (e == 6) ? 2'b01 : 2'b00;
      eh = (e >= 6) ? 2'b01 : 2'b00;
      er = 2'b00;
      checks++;
      if ({press, held, released} !== {ep, eh, er}) begin
        failures++;
        $display("FAIL mid_hold_requalify E%0d got p=%b h=%b r=%b want p=%b h=%b r=%b", e, press, held, released, ep, eh, er);
      end
    end
    btn_n = 2'b11;
    for (int i = 0; i < 10; i++) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    btn_n    = 2'b11;
    test_reset();
    for (int i = 0; i < 4; i++) tick();
    test_clean_press();
    for (int i = 0; i < 4; i++) tick();
    test_bounce_reject();
    for (int i = 0; i < 4; i++) tick();
    test_release_bounce();
    for (int i = 0; i < 4; i++) tick();
    test_auto_repeat();
    for (int i = 0; i < 4; i++) tick();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
